// File: rtl/tt_vec_load_queue.sv
// Load-return queue: buffers OVI load beats ahead of VRF writeback and returns one
// load credit per drained beat.
module tt_vec_load_queue #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned DATA_W = 512,
    parameter int unsigned VREG_W = 5
) (
    input  logic                         i_clk,
    input  logic                         i_reset_n,
    input  logic                         i_load_valid,
    input  logic [DATA_W-1:0]            i_load_data,
    input  logic [DATA_W/8-1:0]          i_load_be,
    input  logic [VREG_W-1:0]            i_load_vd,
    input  logic                         i_flush,
    output logic                         o_wb_valid,
    input  logic                         i_wb_rdy,
    output logic [DATA_W-1:0]            o_wb_data,
    output logic [DATA_W/8-1:0]          o_wb_be,
    output logic [VREG_W-1:0]            o_wb_vd,
    output logic                         o_load_credit,
    output logic                         o_lq_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_overflow
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned BeW  = DATA_W / 8;

    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [BeW-1:0]    be_mem   [DEPTH];
    logic [VREG_W-1:0] vd_mem   [DEPTH];

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            credit_q, credit_d;
    logic            overflow_q, overflow_d;

    logic full;
    logic push;
    logic pop;
    logic overflow_evt;

    assign full         = (count_q == CntW'(DEPTH));
    assign pop          = o_wb_valid && i_wb_rdy && !i_flush;
    // A full queue still accepts a beat when the head drains in the same cycle.
    assign push         = i_load_valid && !i_flush && (!full || pop);
    assign overflow_evt = i_load_valid && full && !pop && !i_flush;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        credit_d   = pop;
        overflow_d = overflow_q | overflow_evt;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            credit_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            credit_q   <= credit_d;
            overflow_q <= overflow_d;
        end
    end

    // Entry storage carries no reset; contents are only observed while o_wb_valid.
    always_ff @(posedge i_clk) begin
        if (push) begin
            data_mem[wr_ptr_q] <= i_load_data;
            be_mem[wr_ptr_q]   <= i_load_be;
            vd_mem[wr_ptr_q]   <= i_load_vd;
        end
    end

    assign o_wb_valid    = (count_q != '0);
    assign o_lq_empty    = (count_q == '0);
    assign o_wb_data     = data_mem[rd_ptr_q];
    assign o_wb_be       = be_mem[rd_ptr_q];
    assign o_wb_vd       = vd_mem[rd_ptr_q];
    assign o_load_credit = credit_q;
    assign o_count       = count_q;
    assign o_overflow    = overflow_q;

endmodule

// File: tb/tb_tt_vec_load_queue.sv
// Randomized bench for tt_vec_load_queue against a queue-based model of the load buffer.
module tb_tt_vec_load_queue;

    localparam int DEPTH  = 8;
    localparam int DATA_W = 512;
    localparam int VREG_W = 5;
    localparam int BE_W   = DATA_W / 8;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic [BE_W-1:0]   be;
        logic [VREG_W-1:0] vd;
    } beat_t;

    logic              i_clk = 1'b0;
    logic              i_reset_n;
    logic              i_load_valid;
    logic [DATA_W-1:0] i_load_data;
    logic [BE_W-1:0]   i_load_be;
    logic [VREG_W-1:0] i_load_vd;
    logic              i_flush;
    logic              o_wb_valid;
    logic              i_wb_rdy;
    logic [DATA_W-1:0] o_wb_data;
    logic [BE_W-1:0]   o_wb_be;
    logic [VREG_W-1:0] o_wb_vd;
    logic              o_load_credit;
    logic              o_lq_empty;
    logic [CNT_W-1:0]  o_count;
    logic              o_overflow;

    tt_vec_load_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .VREG_W(VREG_W)) dut (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .i_load_valid (i_load_valid),
        .i_load_data  (i_load_data),
        .i_load_be    (i_load_be),
        .i_load_vd    (i_load_vd),
        .i_flush      (i_flush),
        .o_wb_valid   (o_wb_valid),
        .i_wb_rdy     (i_wb_rdy),
        .o_wb_data    (o_wb_data),
        .o_wb_be      (o_wb_be),
        .o_wb_vd      (o_wb_vd),
        .o_load_credit(o_load_credit),
        .o_lq_empty   (o_lq_empty),
        .o_count      (o_count),
        .o_overflow   (o_overflow)
    );

    always #5 i_clk = ~i_clk;

    beat_t mq[$];
    bit    exp_credit;
    bit    exp_ovf;
    int    checks;
    int    errors;

    function automatic beat_t rand_beat();
        beat_t b;
        for (int k = 0; k < DATA_W / 32; k++) b.d[k*32 +: 32] = $urandom;
        b.be = {$urandom, $urandom};
        b.vd = VREG_W'($urandom);
        return b;
    endfunction

    task automatic drive_beat(input bit v, input beat_t b);
        i_load_valid = v;
        i_load_data  = b.d;
        i_load_be    = b.be;
        i_load_vd    = b.vd;
    endtask

    // Reference model: advance one clock with the currently driven inputs.
    task automatic cycle();
        bit    pop_e, push_e, ovf_e;
        beat_t nb;
        pop_e  = (mq.size() != 0) && i_wb_rdy && !i_flush;
        push_e = i_load_valid && !i_flush && ((mq.size() < DEPTH) || pop_e);
        ovf_e  = i_load_valid && (mq.size() == DEPTH) && !pop_e && !i_flush;
        nb     = '{d: i_load_data, be: i_load_be, vd: i_load_vd};
        @(posedge i_clk);
        if (!i_reset_n) begin
            mq.delete();
            exp_credit = 1'b0;
            exp_ovf    = 1'b0;
        end else if (i_flush) begin
            mq.delete();
            exp_credit = 1'b0;
        end else begin
            if (pop_e) void'(mq.pop_front());
            if (push_e) mq.push_back(nb);
            exp_credit = pop_e;
            exp_ovf    = exp_ovf | ovf_e;
        end
        #1;
    endtask

    task automatic drain(input string tag, input int exp_n);
        int got;
        got = 0;
        i_wb_rdy = 1'b1;
        drive_beat(1'b0, '0);
        for (int n = 0; n < 40 && mq.size() != 0; n++) begin
            checks++;
            if ({o_wb_valid, o_wb_data, o_wb_be, o_wb_vd} !== {1'b1, mq[0]}) begin
                errors++;
                $display("FAIL %s_head: valid=%0b vd=%0d d0=%h required valid=1 vd=%0d d0=%h",
                         tag, o_wb_valid, o_wb_vd, o_wb_data[31:0], mq[0].vd, mq[0].d[31:0]);
            end
            cycle();
            got++;
            checks++;
            if (o_load_credit !== 1'b1) begin
                errors++;
                $display("FAIL %s_credit: got %b required 1", tag, o_load_credit);
            end
        end
        checks++;
        if (got != exp_n || o_lq_empty !== 1'b1 || o_count !== '0) begin
            errors++;
            $display("FAIL %s_drain: beats=%0d empty=%b count=%0d required beats=%0d empty=1 count=0",
                     tag, got, o_lq_empty, o_count, exp_n);
        end
        cycle();
        checks++;
        if (o_load_credit !== 1'b0) begin
            errors++;
            $display("FAIL %s_credit_end: got %b required 0", tag, o_load_credit);
        end
    endtask

    task automatic fill(input int n);
        i_wb_rdy = 1'b0;
        for (int i = 0; i < n; i++) begin
            drive_beat(1'b1, rand_beat());
            cycle();
        end
        drive_beat(1'b0, '0);
    endtask

    task automatic test_reset();
        i_reset_n = 1'b0;
        i_flush   = 1'b0;
        i_wb_rdy  = 1'b0;
        drive_beat(1'b0, '0);
        cycle();
        cycle();
        i_reset_n = 1'b1;
        checks++;
        if ({o_wb_valid, o_lq_empty, o_load_credit, o_overflow} !== 4'b0100 || o_count !== '0) begin
            errors++;
            $display("FAIL reset: valid=%b empty=%b credit=%b ovf=%b count=%0d required 0 1 0 0 0",
                     o_wb_valid, o_lq_empty, o_load_credit, o_overflow, o_count);
        end
    endtask

    task automatic test_single();
        beat_t b;
        b    = rand_beat();
        b.vd = VREG_W'(3);
        b.be = '1;
        i_wb_rdy = 1'b1;
        drive_beat(1'b1, b);
        cycle();
        drive_beat(1'b0, '0);
        checks++;
        if ({o_wb_valid, o_lq_empty, o_load_credit} !== 3'b100 || o_wb_vd !== VREG_W'(3) ||
            o_wb_be !== {BE_W{1'b1}} || o_wb_data !== b.d) begin
            errors++;
            $display("FAIL single_out: valid=%b empty=%b credit=%b vd=%0d required 1 0 0 vd=3",
                     o_wb_valid, o_lq_empty, o_load_credit, o_wb_vd);
        end
        cycle();
        checks++;
        if (o_lq_empty !== 1'b1 || o_load_credit !== 1'b1) begin
            errors++;
            $display("FAIL single_pop: empty=%b credit=%b required 1 1", o_lq_empty, o_load_credit);
        end
        cycle();
        checks++;
        if (o_load_credit !== 1'b0) begin
            errors++;
            $display("FAIL single_credit_once: got %b required 0", o_load_credit);
        end
    endtask

    task automatic test_fill_drain();
        fill(DEPTH);
        checks++;
        if (o_count !== CNT_W'(DEPTH) || o_overflow !== 1'b0 || o_lq_empty !== 1'b0) begin
            errors++;
            $display("FAIL fill: count=%0d ovf=%b empty=%b required 8 0 0",
                     o_count, o_overflow, o_lq_empty);
        end
        drain("fill", DEPTH);
    endtask

    task automatic test_full_simultaneous();
        fill(DEPTH);
        i_wb_rdy = 1'b1;
        drive_beat(1'b1, rand_beat());
        cycle();
        drive_beat(1'b0, '0);
        i_wb_rdy = 1'b0;
        checks++;
        if (o_count !== CNT_W'(DEPTH) || o_overflow !== 1'b0 || o_load_credit !== 1'b1) begin
            errors++;
            $display("FAIL full_simul: count=%0d ovf=%b credit=%b required 8 0 1",
                     o_count, o_overflow, o_load_credit);
        end
        drain("full_simul", DEPTH);
    endtask

    task automatic test_overflow();
        fill(DEPTH);
        drive_beat(1'b1, rand_beat());
        cycle();
        drive_beat(1'b0, '0);
        checks++;
        if (o_overflow !== 1'b1 || o_count !== CNT_W'(DEPTH) || exp_ovf !== 1'b1) begin
            errors++;
            $display("FAIL overflow_set: ovf=%b count=%0d required 1 8", o_overflow, o_count);
        end
        cycle();
        checks++;
        if (o_overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_sticky: got %b required 1", o_overflow);
        end
        drain("overflow", DEPTH);
        checks++;
        if (o_overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_after_drain: got %b required 1", o_overflow);
        end
    endtask

    task automatic test_wrap();
        int sent, credits, pops;
        sent = 0;
        credits = 0;
        pops = 0;
        for (int n = 0; n < 200 && sent < 20; n++) begin
            drive_beat(mq.size() < DEPTH, rand_beat());
            i_wb_rdy = (n % 2 == 0) ? 1'b1 : ($urandom_range(0, 3) == 0);
            if (o_wb_valid === 1'b1 && i_wb_rdy) begin
                pops++;
                checks++;
                if ({o_wb_data, o_wb_be, o_wb_vd} !== mq[0]) begin
                    errors++;
                    $display("FAIL wrap_order: vd=%0d d0=%h required vd=%0d d0=%h",
                             o_wb_vd, o_wb_data[31:0], mq[0].vd, mq[0].d[31:0]);
                end
            end
            if (i_load_valid) sent++;
            cycle();
            if (o_load_credit === 1'b1) credits++;
            checks++;
            if (o_load_credit !== exp_credit || o_count !== CNT_W'(mq.size())) begin
                errors++;
                $display("FAIL wrap_step: credit=%b count=%0d required %b %0d",
                         o_load_credit, o_count, exp_credit, mq.size());
            end
        end
        checks++;
        if (sent != 20) begin
            errors++;
            $display("FAIL wrap_sent: got %0d required 20", sent);
        end
        drain("wrap", mq.size());
        checks++;
        if (credits + (20 - pops) != 20) begin
            errors++;
            $display("FAIL wrap_credits: got %0d required %0d", credits, pops);
        end
    endtask

    task automatic test_flush();
        beat_t b;
        fill(5);
        i_flush  = 1'b1;
        i_wb_rdy = 1'b1;
        drive_beat(1'b1, rand_beat());
        cycle();
        i_flush = 1'b0;
        drive_beat(1'b0, '0);
        checks++;
        if (o_count !== '0 || o_lq_empty !== 1'b1 || o_wb_valid !== 1'b0 || o_load_credit !== 1'b0)
        begin
            errors++;
            $display("FAIL flush: count=%0d empty=%b valid=%b credit=%b required 0 1 0 0",
                     o_count, o_lq_empty, o_wb_valid, o_load_credit);
        end
        b = rand_beat();
        i_wb_rdy = 1'b0;
        drive_beat(1'b1, b);
        cycle();
        drive_beat(1'b0, '0);
        checks++;
        if (o_wb_valid !== 1'b1 || {o_wb_data, o_wb_be, o_wb_vd} !== b) begin
            errors++;
            $display("FAIL flush_next: valid=%b vd=%0d required 1 vd=%0d", o_wb_valid, o_wb_vd, b.vd);
        end
        drain("flush", 1);
    endtask

    task automatic test_reset_mid_drain();
        fill(4);
        i_wb_rdy = 1'b1;
        cycle();
        i_reset_n = 1'b0;
        cycle();
        i_reset_n = 1'b1;
        checks++;
        if (o_load_credit !== 1'b0 || o_count !== '0 || o_overflow !== 1'b0 || o_lq_empty !== 1'b1)
        begin
            errors++;
            $display("FAIL reset_mid: credit=%b count=%0d ovf=%b empty=%b required 0 0 0 1",
                     o_load_credit, o_count, o_overflow, o_lq_empty);
        end
        cycle();
        checks++;
        if (o_load_credit !== 1'b0 || o_wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_after: credit=%b valid=%b required 0 0",
                     o_load_credit, o_wb_valid);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        exp_credit = 1'b0;
        exp_ovf = 1'b0;
        test_reset();
        test_single();
        test_fill_drain();
        test_full_simultaneous();
        test_overflow();
        test_wrap();
        test_flush();
        test_reset_mid_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
